// File: rtl/jt7759_feeder_if.sv
// Bus bundle between the jt7759 host-side byte feeder and its surroundings.
// Groups the stream control handshake (start/abort/busy/done), the sample
// memory read port (mem_cs/mem_addr/mem_data/mem_ok) and the uPD7759 slave
// write port (drqn/cs/wrn/dout).
//   master : the feeder itself
//   slave  : host, memory and chip side
interface jt7759_feeder_if #(
    parameter int unsigned AW = 17,
    parameter int unsigned LW = 16
);
    // stream control
    logic          start;
    logic [AW-1:0] start_addr;
    logic [LW-1:0] length;
    logic          abort;
    logic          busy;
    logic          done;
    // sample memory
    logic          mem_cs;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          mem_ok;
    // chip write port
    logic          drqn;
    logic          cs;
    logic          wrn;
    logic [7:0]    dout;

    modport master (
        input  start, start_addr, length, abort, mem_data, mem_ok, drqn,
        output busy, done, mem_cs, mem_addr, cs, wrn, dout
    );

    modport slave (
        output start, start_addr, length, abort, mem_data, mem_ok, drqn,
        input  busy, done, mem_cs, mem_addr, cs, wrn, dout
    );
endinterface

// File: rtl/jt7759_feeder.sv
// Host-side byte streamer for a uPD7759 in slave mode. Fetches one byte at a
// time from sample memory and writes it to the chip each time DRQn is asserted.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   cen  - clock enable that times the write strobe
//   bus  - jt7759_feeder_if master: stream control, memory read, chip write
module jt7759_feeder #(
    parameter int unsigned AW     = 17,
    parameter int unsigned LW     = 16,
    parameter int unsigned WR_LEN = 4
) (
    input logic             clk,
    input logic             rst,
    input logic             cen,
    jt7759_feeder_if.master bus
);
    localparam int unsigned CW = $clog2(WR_LEN + 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWaitReq,
        StStrobe,
        StWaitRel
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [7:0]    buf_q, buf_d;
    logic [7:0]    dout_q, dout_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cs_q, cs_d;
    logic          wrn_q, wrn_d;
    logic          done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rem_q   <= '0;
            buf_q   <= '0;
            dout_q  <= '0;
            cnt_q   <= '0;
            cs_q    <= 1'b0;
            wrn_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            buf_q   <= buf_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            wrn_q   <= wrn_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        buf_d   = buf_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        cs_d    = cs_q;
        wrn_d   = wrn_q;
        done_d  = 1'b0;

        // Abort beats everything, including a simultaneous start.
        if (state_q != StIdle && bus.abort) begin
            state_d = StIdle;
            cs_d    = 1'b0;
            wrn_d   = 1'b1;
            done_d  = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        rem_d = bus.length;
                        if (bus.length == '0) begin
                            done_d = 1'b1;
                        end else begin
                            addr_d  = bus.start_addr;
                            state_d = StFetch;
                        end
                    end
                end
                StFetch: begin
                    if (bus.mem_ok) begin
                        buf_d   = bus.mem_data;
                        addr_d  = addr_q + AW'(1);
                        state_d = StWaitReq;
                    end
                end
                StWaitReq: begin
                    // Strobe starts on a cen tick so its width is whole cen periods.
                    if (!bus.drqn && cen) begin
                        dout_d  = buf_q;
                        cs_d    = 1'b1;
                        wrn_d   = 1'b0;
                        cnt_d   = CW'(WR_LEN);
                        state_d = StStrobe;
                    end
                end
                StStrobe: begin
                    // Full width regardless of drqn; release on the tick reaching zero.
                    if (cen) begin
                        if (cnt_q == CW'(1)) begin
                            cnt_d   = '0;
                            cs_d    = 1'b0;
                            wrn_d   = 1'b1;
                            rem_d   = rem_q - LW'(1);
                            state_d = StWaitRel;
                        end else begin
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                end
                StWaitRel: begin
                    // One byte per request: the chip must drop its request first.
                    if (bus.drqn) begin
                        if (rem_q == '0) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end else begin
                            state_d = StFetch;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = done_q;
    assign bus.mem_cs   = (state_q == StFetch);
    assign bus.mem_addr = addr_q;
    assign bus.cs       = cs_q;
    assign bus.wrn      = wrn_q;
    assign bus.dout     = dout_q;
endmodule

// File: tb/tb_jt7759_feeder.sv
// Bench for jt7759_feeder: random memory latency, a DRQ-driven chip model and a
// scoreboard of expected bytes and per-stream byte counts checked by a monitor.
module tb_jt7759_feeder;
    localparam int unsigned AW     = 17;
    localparam int unsigned LW     = 16;
    localparam int unsigned WR_LEN = 4;

    logic clk;
    logic rst;
    logic cen;

    jt7759_feeder_if #(.AW(AW), .LW(LW)) bus ();

    jt7759_feeder #(.AW(AW), .LW(LW), .WR_LEN(WR_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cen_div = 1;
    int mem_lat = -1;
    int drq_mode = 0;    // 0: idle high, 1: chip-like pulses, 2: held low
    int done_cnt = 0;
    int stream_bytes = 0;
    int cut_req = 0;
    int cut_ack = 0;
    int late_req = 0;
    int late_ack = 0;

    logic [7:0]    exp_bytes[$];
    int            exp_done[$];
    logic [AW-1:0] fetch_log[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not reach its end");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
        logic [31:0] x;
        x = 32'(a) * 32'd37 + (32'(a) >> 9);
        return x[7:0] ^ 8'h5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // cen generator: one tick every cen_div clocks
    initial begin
        int ph = 0;
        cen = 1'b0;
        forever begin
            @(posedge clk); #1;
            ph = (ph + 1) % cen_div;
            cen = (ph == 0);
        end
    end

    // Sample memory with arbitrary latency; answers even if mem_cs is withdrawn.
    initial begin
        int lat;
        bus.mem_ok = 1'b0;
        bus.mem_data = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (bus.mem_cs || late_req != late_ack) begin
                if (bus.mem_cs) fetch_log.push_back(bus.mem_addr);
                late_ack = late_req;
                lat = (mem_lat >= 0) ? mem_lat : int'($urandom_range(0, 3));
                repeat (lat) begin
                    @(posedge clk); #1;
                end
                bus.mem_data = mem_byte(bus.mem_addr);
                bus.mem_ok = 1'b1;
                @(posedge clk); #1;
                bus.mem_ok = 1'b0;
                bus.mem_data = 8'h00;
            end
        end
    end

    // Chip model: request, wait for the write, release after a random delay,
    // and only re-request once the release has been visible for two clocks.
    initial begin
        int hold = 0;
        int hi_cnt = 0;
        bit served = 1'b0;
        bus.drqn = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (drq_mode == 0) begin
                bus.drqn = 1'b1;
                served = 1'b0;
            end else if (drq_mode == 2) begin
                bus.drqn = 1'b0;
                served = 1'b0;
            end else if (!bus.drqn) begin
                if (!served && !bus.wrn) begin
                    served = 1'b1;
                    hold = int'($urandom_range(0, 4));
                end else if (served) begin
                    if (hold == 0) begin
                        bus.drqn = 1'b1;
                        served = 1'b0;
                    end else begin
                        hold--;
                    end
                end
            end else if (hi_cnt >= 2 && $urandom_range(0, 2) == 0) begin
                bus.drqn = 1'b0;
            end
            hi_cnt = (bus.drqn && bus.wrn) ? hi_cnt + 1 : 0;
        end
    end

    // Monitor: pops the scoreboard on every strobe and every done pulse.
    initial begin
        bit         prev_cs = 1'b0;
        bit         prev_done = 1'b0;
        bit         bad = 1'b0;
        int         width = 0;
        logic [7:0] held = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                stream_bytes = 0;
                prev_cs = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (bus.cs && !prev_cs) begin
                    stream_bytes++;
                    check("strobe_expected", 32'(exp_bytes.size() != 0), 1);
                    if (exp_bytes.size() != 0) check("dout", bus.dout, exp_bytes.pop_front());
                    width = 0;
                    bad = 1'b0;
                    held = bus.dout;
                end
                if (bus.cs) begin
                    width++;
                    if (bus.wrn !== 1'b0 || bus.dout !== held) bad = 1'b1;
                end
                if (!bus.cs && prev_cs) begin
                    check("strobe_shape", 32'(bad), 0);
                    check("wrn_release", bus.wrn, 1);
                    if (cut_ack != cut_req) cut_ack = cut_req;
                    else check("wrn_width", width, WR_LEN * cen_div);
                end
                if (bus.done) begin
                    done_cnt++;
                    check("done_single", 32'(prev_done), 0);
                    check("done_expected", 32'(exp_done.size() != 0), 1);
                    if (exp_done.size() != 0) check("stream_bytes", stream_bytes,
                                                    exp_done.pop_front());
                    stream_bytes = 0;
                end
                prev_cs = bus.cs;
                prev_done = bus.done;
            end
        end
    end

    task automatic start_stream(input logic [AW-1:0] addr, input logic [LW-1:0] len);
        bus.start = 1'b1;
        bus.start_addr = addr;
        bus.length = len;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string name);
        int k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, 32'(done_cnt != d0), 1);
    endtask

    task automatic wait_strobe(input int n, input int budget, input string name);
        int k = 0;
        while (!(stream_bytes >= n && bus.cs) && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, 32'(stream_bytes >= n && bus.cs), 1);
    endtask

    // Reference: stream bytes are memory contents at consecutive wrapped addresses.
    task automatic expect_stream(input logic [AW-1:0] addr, input logic [LW-1:0] len);
        logic [AW-1:0] a;
        a = addr;
        for (int i = 0; i < int'(len); i++) begin
            exp_bytes.push_back(mem_byte(a));
            a = a + AW'(1);
        end
        exp_done.push_back(int'(len));
    endtask

    task automatic run_stream(input logic [AW-1:0] addr, input logic [LW-1:0] len);
        int d0;
        expect_stream(addr, len);
        d0 = done_cnt;
        start_stream(addr, len);
        wait_done(d0, 100 * int'(len) + 50, "stream_done");
    endtask

    initial begin
        int d0;
        bus.start = 1'b0;
        bus.start_addr = '0;
        bus.length = '0;
        bus.abort = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_mem_cs", bus.mem_cs, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_cs", bus.cs, 0);
        check("rst_wrn", bus.wrn, 1);
        check("rst_dout", bus.dout, 0);
        rst = 1'b0;
        drq_mode = 1;

        // basic three-byte stream, fixed memory latency
        mem_lat = 2;
        run_stream(17'h00100, 16'd3);
        check("t1_mem_addr_end", bus.mem_addr, 17'h00103);
        mem_lat = -1;

        // strobe width with cen every second clock
        cen_div = 2;
        run_stream(17'h02345, 16'd3);
        cen_div = 1;

        // drqn held low: only one strobe until it rises and falls again
        drq_mode = 2;
        expect_stream(17'h04000, 16'd2);
        d0 = done_cnt;
        start_stream(17'h04000, 16'd2);
        wait_strobe(1, 200, "held_first_strobe");
        repeat (40) begin
            @(posedge clk); #1;
        end
        check("held_one_strobe", stream_bytes, 1);
        check("held_busy", bus.busy, 1);
        drq_mode = 0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        drq_mode = 1;
        wait_done(d0, 300, "held_done");

        // zero-length stream
        exp_done.push_back(0);
        start_stream(17'h00500, 16'd0);
        check("len0_done", bus.done, 1);
        check("len0_busy", bus.busy, 0);
        check("len0_mem_cs", bus.mem_cs, 0);
        check("len0_cs", bus.cs, 0);
        @(posedge clk); #1;
        check("len0_done_pulse", bus.done, 0);

        // address wrap
        fetch_log.delete();
        run_stream(17'h1FFFF, 16'd2);
        check("wrap_fetches", fetch_log.size(), 2);
        if (fetch_log.size() == 2) begin
            check("wrap_fetch0", fetch_log[0], 17'h1FFFF);
            check("wrap_fetch1", fetch_log[1], 17'h00000);
        end
        check("wrap_mem_addr_end", bus.mem_addr, 17'h00001);

        // abort in the middle of the second strobe, then a stray mem_ok
        expect_stream(17'h00700, 16'd5);
        d0 = done_cnt;
        start_stream(17'h00700, 16'd5);
        wait_strobe(2, 300, "abort_reach_strobe");
        exp_done[exp_done.size() - 1] = 2;
        exp_bytes.delete();
        cut_req++;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check("abort_cs", bus.cs, 0);
        check("abort_wrn", bus.wrn, 1);
        check("abort_mem_cs", bus.mem_cs, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 1);
        late_req++;
        repeat (8) begin
            @(posedge clk); #1;
        end
        check("late_ok_busy", bus.busy, 0);
        check("late_ok_cs", bus.cs, 0);
        check("abort_done_once", done_cnt, d0 + 1);

        // start together with abort while busy: abort wins, start dropped
        exp_done.push_back(0);
        start_stream(17'h00777, 16'd4);
        check("sa_busy_before", bus.busy, 1);
        bus.start = 1'b1;
        bus.start_addr = 17'h01234;
        bus.length = 16'd3;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("sa_busy", bus.busy, 0);
        check("sa_done", bus.done, 1);
        @(posedge clk); #1;
        check("sa_start_dropped", bus.busy, 0);
        repeat (8) begin
            @(posedge clk); #1;
        end

        // abort while idle does nothing
        d0 = done_cnt;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check("idle_abort_done", bus.done, 0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("idle_abort_no_done", done_cnt, d0);

        // reset in the middle of a strobe
        expect_stream(17'h00900, 16'd4);
        start_stream(17'h00900, 16'd4);
        wait_strobe(1, 200, "rst_reach_strobe");
        exp_bytes.delete();
        exp_done.delete();
        rst = 1'b1;
        @(posedge clk); #1;
        check("mrst_cs", bus.cs, 0);
        check("mrst_wrn", bus.wrn, 1);
        check("mrst_busy", bus.busy, 0);
        check("mrst_mem_cs", bus.mem_cs, 0);
        check("mrst_mem_addr", bus.mem_addr, 0);
        check("mrst_dout", bus.dout, 0);
        rst = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        check("mrst_stays_idle", bus.busy, 0);

        // random streams
        for (int n = 0; n < 10; n++) begin
            cen_div = int'($urandom_range(1, 2));
            run_stream(AW'($urandom), LW'($urandom_range(1, 6)));
            repeat (int'($urandom_range(0, 3))) begin
                @(posedge clk); #1;
            end
        end
        cen_div = 1;

        check("sb_bytes_left", exp_bytes.size(), 0);
        check("sb_done_left", exp_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
